// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory stage and the control unit.
package data_mem_pkg;

  // Load/store access type carried on memOp
  typedef enum logic [2:0] {
    MEM_W  = 3'b000,
    MEM_H  = 3'b001,
    MEM_HU = 3'b010,
    MEM_B  = 3'b011,
    MEM_BU = 3'b100
  } memOp_e;

  // Data memory geometry
  localparam int unsigned DM_WORDS = 3072;
  localparam int unsigned DM_SIZE  = DM_WORDS * 4;

  // Write trace: pc, word-aligned byte address, merged word
  localparam string TRACE_FMT = "@%08h: *%08h <= %08h";

endpackage

// File: rtl/data_mem_ext.sv
// Load lane select plus sign/zero extension for the data memory read path.
module dm_ext
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  memOp,
  output logic [31:0] rData
);

  memOp_e op;
  logic [15:0] half;
  logic [7:0]  byteVal;

  assign op = memOp_e'(memOp);

  // Select the addressed half and byte from the word
  always_comb begin
    half = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    byteVal = word[7:0];
      2'd1:    byteVal = word[15:8];
      2'd2:    byteVal = word[23:16];
      default: byteVal = word[31:24];
    endcase
  end

  // Extend the selected lane to 32 bits according to the access type
  always_comb begin
    rData = '0;
    case (op)
      MEM_W:   rData = word;
      MEM_H:   rData = {{16{half[15]}}, half};
      MEM_HU:  rData = {16'h0000, half};
      MEM_B:   rData = {{24{byteVal[7]}}, byteVal};
      MEM_BU:  rData = {24'h000000, byteVal};
      default: rData = '0;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Data memory: word array with lane-merging stores, combinational
// extended loads, address/op error detection and a simulation write trace.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = DM_WORDS,
  parameter int unsigned ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  input  logic        memWrite,
  input  logic [2:0]  memOp,
  input  logic [31:0] pc,
  output logic [31:0] rData,
  output logic        addrErr
);

  logic [31:0] mem [DEPTH];

  memOp_e            op;
  logic [ADDR_W-1:0] idx;
  logic              inRange;
  logic [31:0]       curWord;
  logic [31:0]       merged;
  logic [31:0]       extData;

  assign op      = memOp_e'(memOp);
  assign idx     = addr[ADDR_W+1:2];
  assign inRange = addr < 32'(4 * DEPTH);

  // Current word; out-of-range addresses never index the array
  assign curWord = inRange ? mem[idx] : '0;

  // Flag misaligned, out-of-range and invalid-op accesses
  always_comb begin
    addrErr = !inRange;
    case (op)
      MEM_W:         if (addr[1:0] != 2'b00) addrErr = 1'b1;
      MEM_H, MEM_HU: if (addr[0]) addrErr = 1'b1;
      MEM_B, MEM_BU: ;
      default:       addrErr = 1'b1;
    endcase
  end

  // Merge store data into the selected lanes, keeping the rest intact
  always_comb begin
    merged = curWord;
    case (op)
      MEM_W: merged = wData;
      MEM_H, MEM_HU: begin
        if (addr[1]) merged[31:16] = wData[15:0];
        else         merged[15:0]  = wData[15:0];
      end
      MEM_B, MEM_BU: begin
        case (addr[1:0])
          2'd0:    merged[7:0]   = wData[7:0];
          2'd1:    merged[15:8]  = wData[7:0];
          2'd2:    merged[23:16] = wData[7:0];
          default: merged[31:24] = wData[7:0];
        endcase
      end
      default: merged = curWord;
    endcase
  end

  // Clear all words on reset; commit merged word on a valid store
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (memWrite && !addrErr) begin
      mem[idx] <= merged;
    end
  end

  dm_ext uExt (
    .word  (curWord),
    .lane  (addr[1:0]),
    .memOp (memOp),
    .rData (extData)
  );

  // Erroneous accesses read as zero
  assign rData = addrErr ? '0 : extData;

`ifndef SYNTHESIS
  // Print one trace line per committed store
  always_ff @(posedge clk) begin
    if (!reset && memWrite && !addrErr)
      $display(TRACE_FMT, pc, {addr[31:2], 2'b00}, merged);
  end
`endif

endmodule

// File: tb/tb_data_mem.sv
// Directed, table-driven bench for data_mem.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wData;
  logic        memWrite;
  logic [2:0]  memOp;
  logic [31:0] pc;
  logic [31:0] rData;
  logic        addrErr;

  int nCmp = 0;
  int nBad = 0;

  data_mem dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wData    (wData),
    .memWrite (memWrite),
    .memOp    (memOp),
    .pc       (pc),
    .rData    (rData),
    .addrErr  (addrErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wData;
    logic [31:0] pc;
    logic [31:0] expData;   // rData before the edge
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  localparam logic [2:0] W = 3'b000, H = 3'b001, HU = 3'b010, B = 3'b011, BU = 3'b100;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] expD, input logic expE);
    vecs.push_back('{we: we, op: op, addr: a, wData: d, pc: 32'h0000_3000,
                     expData: expD, expErr: expE});
  endtask

  initial begin
    reset = 1'b1; addr = '0; wData = '0; memWrite = 1'b0; memOp = W; pc = '0;

    // {we, op, addr, wData, expected rData, expected addrErr}
    add(0, W,  32'h0000_0000, 0,             32'h0000_0000, 0);
    add(1, W,  32'h0000_0010, 32'hDEADBEEF,  32'h0000_0000, 0);
    add(0, W,  32'h0000_0010, 0,             32'hDEADBEEF, 0);
    add(1, B,  32'h0000_0022, 32'h0000_0080, 32'h0000_0000, 0);
    add(0, W,  32'h0000_0020, 0,             32'h0080_0000, 0);
    add(0, B,  32'h0000_0022, 0,             32'hFFFF_FF80, 0);
    add(0, BU, 32'h0000_0022, 0,             32'h0000_0080, 0);
    add(1, W,  32'h0000_0030, 32'h11223344,  32'h0000_0000, 0);
    add(1, H,  32'h0000_0032, 32'h0000_BEEF, 32'h0000_1122, 0);
    add(0, W,  32'h0000_0030, 0,             32'hBEEF_3344, 0);
    add(0, H,  32'h0000_0032, 0,             32'hFFFF_BEEF, 0);
    add(0, HU, 32'h0000_0030, 0,             32'h0000_3344, 0);
    add(0, B,  32'h0000_0031, 0,             32'h0000_0033, 0);
    add(0, B,  32'h0000_0033, 0,             32'hFFFF_FFBE, 0);
    add(0, HU, 32'h0000_0032, 0,             32'h0000_BEEF, 0);
    // error cases: writes suppressed, rData forced to 0
    add(1, W,  32'h0000_0013, 32'hFFFFFFFF,  32'h0000_0000, 1);
    add(0, W,  32'h0000_0010, 0,             32'hDEADBEEF, 0);
    add(1, H,  32'h0000_0031, 32'h0000_FFFF, 32'h0000_0000, 1);
    add(0, W,  32'h0000_0030, 0,             32'hBEEF_3344, 0);
    add(1, W,  32'h0000_3000, 32'h0000_0001, 32'h0000_0000, 1);
    add(1, B,  32'h0000_4010, 32'h0000_0055, 32'h0000_0000, 1);
    add(0, W,  32'h0000_0010, 0,             32'hDEADBEEF, 0);
    add(1, 3'b111, 32'h0000_0020, 32'hFFFFFFFF, 32'h0000_0000, 1);
    add(0, W,  32'h0000_0020, 0,             32'h0080_0000, 0);
    add(0, 3'b101, 32'h0000_0010, 0,         32'h0000_0000, 1);
    add(0, B,  32'h0000_0023, 0,             32'h0000_0000, 0);
    // top-of-memory boundary
    add(1, W,  32'h0000_2FFC, 32'hCAFEF00D,  32'h0000_0000, 0);
    add(0, BU, 32'h0000_2FFF, 0,             32'h0000_00CA, 0);
    add(0, W,  32'h0000_2FFC, 0,             32'hCAFE_F00D, 0);
    add(1, W,  32'h0000_0040, 32'h0000_0001, 32'h0000_0000, 0);

    @(negedge clk);
    reset = 1'b0;

    // Each vector: drive after negedge, check before posedge, posedge commits
    foreach (vecs[i]) begin
      @(negedge clk);
      memWrite = vecs[i].we;
      memOp    = vecs[i].op;
      addr     = vecs[i].addr;
      wData    = vecs[i].wData;
      pc       = vecs[i].pc;
      #2;
      check32($sformatf("vec%0d rData", i), rData, vecs[i].expData);
      check1($sformatf("vec%0d addrErr", i), addrErr, vecs[i].expErr);
    end

    // Read-during-write: old value before the edge, new value after
    @(negedge clk);
    memWrite = 1'b1; memOp = W; addr = 32'h40; wData = 32'hAAAA5555;
    #2;
    check32("rdw before edge", rData, 32'h0000_0001);
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    check32("rdw after edge", rData, 32'hAAAA5555);

    // Store at 0x0, then asynchronous reset mid-cycle clears it
    @(negedge clk);
    memWrite = 1'b1; memOp = W; addr = 32'h0; wData = 32'h12345678;
    @(negedge clk);
    memWrite = 1'b0;
    #2;
    check32("pre-reset word0", rData, 32'h12345678);
    #1;
    reset = 1'b1;
    #1;
    check32("async reset word0", rData, 32'h0000_0000);
    addr = 32'h10;
    #0.5;
    check32("async reset word4", rData, 32'h0000_0000);

    // Write held across a posedge while reset is high is discarded
    addr = 32'h0; wData = 32'h00000077; memWrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; memWrite = 1'b0;
    #2;
    check32("write during reset", rData, 32'h0000_0000);
    check1("addrErr during reset", addrErr, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
